// File: rtl/usb_fifo_emu.sv
// rtl/usb_fifo_emu.sv - FT2232H synchronous 245 FIFO model: host stream port to RX/TX FIFOs behind chip-accurate flags.
// Optional protocol checker on err_o is built when USB_FIFO_EMU_CHECK_EN is defined.
module usb_fifo_emu #(
    parameter int USBDW      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    inout  wire  [USBDW-1:0] data_io,
    output logic             rxf_n_o,
    output logic             txe_n_o,
    input  logic             rd_n_i,
    input  logic             wr_n_i,
    input  logic             oe_n_i,
    input  logic [USBDW-1:0] host_wdata_i,
    input  logic             host_wvalid_i,
    output logic             host_wready_o,
    output logic [USBDW-1:0] host_rdata_o,
    output logic             host_rvalid_o,
    input  logic             host_rready_i,
    output logic             err_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] ZERO_CNT = '0;

    logic [USBDW-1:0]      rx_mem [DEPTH];
    logic [USBDW-1:0]      tx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rx_wr_ptr, rx_rd_ptr, tx_wr_ptr, tx_rd_ptr;
    logic [DEPTH_LOG2:0]   rx_count, tx_count, rx_count_nxt, tx_count_nxt;
    logic                  rx_push, rx_pop, tx_push, tx_pop;

    assign host_wready_o = (rx_count != FULL_CNT);
    assign host_rvalid_o = (tx_count != ZERO_CNT);
    assign host_rdata_o  = tx_mem[tx_rd_ptr];

    // The registered flags gate the bus-side operations, so they can never overrun or underrun.
    assign rx_push = host_wvalid_i && host_wready_o;
    assign rx_pop  = !rd_n_i && !oe_n_i && !rxf_n_o;
    assign tx_push = !wr_n_i && !txe_n_o;
    assign tx_pop  = host_rvalid_o && host_rready_i;

    assign rx_count_nxt = rx_count + {{DEPTH_LOG2{1'b0}}, rx_push} - {{DEPTH_LOG2{1'b0}}, rx_pop};
    assign tx_count_nxt = tx_count + {{DEPTH_LOG2{1'b0}}, tx_push} - {{DEPTH_LOG2{1'b0}}, tx_pop};

    assign data_io = (!oe_n_i && !rxf_n_o) ? rx_mem[rx_rd_ptr] : {USBDW{1'bz}};

    always_ff @(posedge clk_i) begin
        if (rx_push) begin
            rx_mem[rx_wr_ptr] <= host_wdata_i;
        end
        if (tx_push) begin
            tx_mem[tx_wr_ptr] <= data_io;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
            rxf_n_o   <= 1'b1;
            txe_n_o   <= 1'b1;
        end else begin
            if (rx_push) begin
                rx_wr_ptr <= rx_wr_ptr + 1'b1;
            end
            if (rx_pop) begin
                rx_rd_ptr <= rx_rd_ptr + 1'b1;
            end
            if (tx_push) begin
                tx_wr_ptr <= tx_wr_ptr + 1'b1;
            end
            if (tx_pop) begin
                tx_rd_ptr <= tx_rd_ptr + 1'b1;
            end
            rx_count <= rx_count_nxt;
            tx_count <= tx_count_nxt;
            rxf_n_o  <= (rx_count_nxt == ZERO_CNT);
            txe_n_o  <= (tx_count_nxt == FULL_CNT);
        end
    end

`ifdef USB_FIFO_EMU_CHECK_EN
    logic oe_n_q;
    logic err_q;

    // oe_n_q holds OE as sampled on the previous edge, for the OE-before-RD rule.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            oe_n_q <= 1'b1;
            err_q  <= 1'b0;
        end else begin
            oe_n_q <= oe_n_i;
            if ((!oe_n_i && !wr_n_i) ||
                (!rd_n_i && oe_n_q) ||
                (!rd_n_i && rxf_n_o) ||
                (!wr_n_i && txe_n_o)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_usb_fifo_emu.sv
// tb/tb_usb_fifo_emu.sv - queue-model bench for usb_fifo_emu; checker cases run when USB_FIFO_EMU_CHECK_EN is defined.
module tb_usb_fifo_emu;

    localparam int W = 8;
    localparam int D = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, rd_n, wr_n, oe_n, wvalid, rready;
    logic [W-1:0] wdata, tb_data;
    tri1  [W-1:0] data_io;
    wire          rxf_n, txe_n, wready, rvalid, err;
    wire  [W-1:0] rdata;

    assign data_io = wr_n ? {W{1'bz}} : tb_data;

    usb_fifo_emu #(.USBDW(W), .DEPTH_LOG2(4)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .data_io(data_io),
        .rxf_n_o(rxf_n), .txe_n_o(txe_n), .rd_n_i(rd_n), .wr_n_i(wr_n), .oe_n_i(oe_n),
        .host_wdata_i(wdata), .host_wvalid_i(wvalid), .host_wready_o(wready),
        .host_rdata_o(rdata), .host_rvalid_o(rvalid), .host_rready_i(rready),
        .err_o(err)
    );

    logic [W-1:0] rx_q[$];
    logic [W-1:0] tx_q[$];
    bit           mrxf = 1'b1;
    bit           mtxe = 1'b1;
    logic         exp_err = 1'b0;
    int           n_checks = 0;
    int           n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [W-1:0] bus_exp;
        if (!oe_n && !mrxf)   bus_exp = rx_q[0];
        else if (!wr_n)       bus_exp = tb_data;
        else                  bus_exp = 8'hff;
        check("rxf_n", rxf_n, mrxf);
        check("txe_n", txe_n, mtxe);
        check("wready", wready, rx_q.size() != D);
        check("rvalid", rvalid, tx_q.size() != 0);
        if (tx_q.size() > 0) check("rdata", rdata, tx_q[0]);
        check("data_io", data_io, bus_exp);
        check("err", err, exp_err);
    endtask

    // One clock edge: apply the spec's push/pop rules to the queues, then compare.
    task automatic step();
        bit rxpush, rxpop, txpush, txpop;
        logic [W-1:0] din, hin;
        rxpush = wvalid && (rx_q.size() < D);
        rxpop  = !rd_n && !oe_n && !mrxf;
        txpush = !wr_n && !mtxe;
        txpop  = rready && (tx_q.size() > 0);
        din    = tb_data;
        hin    = wdata;
        @(posedge clk);
        if (!rst_n) begin
            rx_q.delete();
            tx_q.delete();
            mrxf = 1'b1;
            mtxe = 1'b1;
        end else begin
            if (rxpop)  void'(rx_q.pop_front());
            if (rxpush) rx_q.push_back(hin);
            if (txpop)  void'(tx_q.pop_front());
            if (txpush) tx_q.push_back(din);
            mrxf = (rx_q.size() == 0);
            mtxe = (tx_q.size() == D);
        end
        #1;
        check_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        logic [W-1:0] hb [3];
        int mode;
        hb[0] = 8'h11; hb[1] = 8'h22; hb[2] = 8'h33;

        rst_n = 1'b0; rd_n = 1'b1; wr_n = 1'b1; oe_n = 1'b0;
        wvalid = 1'b0; rready = 1'b0; wdata = '0; tb_data = '0;
        steps(2);
        check("rst_rxf", rxf_n, 1'b1);
        check("rst_txe", txe_n, 1'b1);
        check("rst_bus_z", data_io, 8'hff);
        check("rst_err", err, 1'b0);
        rst_n = 1'b1; oe_n = 1'b1;
        #1 check("rel_txe_before_edge", txe_n, 1'b1);
        step();
        check("rel_txe_after_edge", txe_n, 1'b0);

        // Host to FPGA
        wvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wdata = hb[i];
            step();
        end
        wvalid = 1'b0;
        oe_n = 1'b0;
        step();
        check("h2f_first", data_io, 8'h11);
        rd_n = 1'b0;
        step();
        check("h2f_second", data_io, 8'h22);
        step();
        check("h2f_third", data_io, 8'h33);
        step();
        check("h2f_empty_rxf", rxf_n, 1'b1);
        check("h2f_err", err, 1'b0);
        rd_n = 1'b1; oe_n = 1'b1;
        step();

        // Full TX FIFO
        wr_n = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tb_data = W'($urandom);
            step();
        end
        check("full_txe", txe_n, 1'b1);
        wr_n = 1'b1; rready = 1'b1;
        steps(16);
        check("drain_txe", txe_n, 1'b0);
        check("drain_rvalid", rvalid, 1'b0);
        rready = 1'b0;

        // Simultaneous push and pop at 15 entries, across pointer wrap
        wr_n = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tb_data = W'($urandom);
            step();
        end
        rready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tb_data = W'($urandom);
            step();
            check("sim_txe", txe_n, 1'b0);
        end
        wr_n = 1'b1;
        steps(16);
        rready = 1'b0;

        // Random traffic that respects the bus protocol
        mode = 0;
        for (int i = 0; i < 300; i++) begin
            if (i % 8 == 0) mode = int'($urandom_range(1, 0));
            if (mode == 1) begin
                wr_n = 1'b1;
                if (oe_n) begin
                    oe_n = 1'b0;
                    rd_n = 1'b1;
                end else begin
                    rd_n = !(!mrxf && $urandom_range(1, 0) == 1);
                end
            end else begin
                oe_n = 1'b1;
                rd_n = 1'b1;
                wr_n = !(!mtxe && $urandom_range(1, 0) == 1);
                tb_data = W'($urandom);
            end
            wvalid = $urandom_range(1, 0) == 1;
            wdata  = W'($urandom);
            rready = $urandom_range(1, 0) == 1;
            step();
        end
        rd_n = 1'b1; wr_n = 1'b1; oe_n = 1'b1; wvalid = 1'b0; rready = 1'b0;
        step();

        // Reset mid-read
        wvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wdata = W'($urandom_range(8'hfe, 0));
            step();
        end
        wvalid = 1'b0;
        oe_n = 1'b0;
        step();
        rd_n = 1'b0;
        steps(2);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_bus_z", data_io, 8'hff);
        check("mid_rst_rxf", rxf_n, 1'b1);
        check("mid_rst_wready", wready, 1'b1);
        check("mid_rst_rvalid", rvalid, 1'b0);
        rx_q.delete(); tx_q.delete(); mrxf = 1'b1; mtxe = 1'b1;
        rd_n = 1'b1; oe_n = 1'b1;
        steps(2);
        rst_n = 1'b1;
        step();
        check("post_rst_txe", txe_n, 1'b0);
        check("post_rst_rxf", rxf_n, 1'b1);

`ifdef USB_FIFO_EMU_CHECK_EN
        // Bus contention
        oe_n = 1'b0; wr_n = 1'b0; tb_data = 8'h5a;
        exp_err = 1'b1;
        step();
        oe_n = 1'b1; wr_n = 1'b1;
        steps(3);
        check("err_sticky", err, 1'b1);
        rst_n = 1'b0;
        exp_err = 1'b0;
        #1 check("err_rst_clear", err, 1'b0);
        rx_q.delete(); tx_q.delete(); mrxf = 1'b1; mtxe = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        // RD in the same cycle OE first falls
        wvalid = 1'b1; wdata = 8'h44;
        step();
        wvalid = 1'b0;
        oe_n = 1'b0; rd_n = 1'b0;
        exp_err = 1'b1;
        step();
        check("err_oe_rd", err, 1'b1);
        rd_n = 1'b1; oe_n = 1'b1;
        step();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/usb_fifo_emu.md
# usb_fifo_emu

FPGA-side model of the FT2232H synchronous 245 FIFO chip. It sits across `data_io`/`rxf_n`/`txe_n`/`rd_n`/`wr_n`/`oe_n` from the `usb` interface block and lets us run loopback and bring-up without the physical USB part. A host-side stream port fills a host-to-FPGA RX FIFO and drains an FPGA-to-host TX FIFO. Pin behaviour and flag timing are the chip's, at the cycle level.

## Interface
- `USBDW`, 8, data bus width.
- `DEPTH_LOG2`, 4, log2 of each FIFO's depth (16 entries). Both FIFOs use it.

- `clk_i`  in  1  60 MHz bus clock; every state element is updated on its rising edge.
- `rst_n_i`  in  1  asynchronous, active-low reset.
- `data_io`  inout  USBDW  shared bus.
- `rxf_n_o`  out  1  low while the RX FIFO holds data.
- `txe_n_o`  out  1  low while the TX FIFO can accept data.
- `rd_n_i`  in  1  read strobe from `usb`.
- `wr_n_i`  in  1  write strobe from `usb`.
- `oe_n_i`  in  1  output enable from `usb`.
- `host_wdata_i`  in  USBDW  host byte to the FPGA.
- `host_wvalid_i`  in  1  `host_wdata_i` valid.
- `host_wready_o`  out  1  RX FIFO not full.
- `host_rdata_o`  out  USBDW  head of the TX FIFO.
- `host_rvalid_o`  out  1  TX FIFO not empty.
- `host_rready_i`  in  1  host accepts `host_rdata_o`.
- `err_o`  out  1  sticky protocol-error flag (see Configuration).

## Operation
- **Buffers.** Two independent circular FIFOs. Each has:
  - a `DEPTH_LOG2`-bit write pointer and read pointer, wrapping naturally from 2^DEPTH_LOG2-1 to 0;
  - a `DEPTH_LOG2+1`-bit occupancy count.
- **RX FIFO (host to FPGA).**
  - Host push occurs when `host_wvalid_i && host_wready_o`. `host_wready_o` is combinational: count != DEPTH.
  - Bus pop occurs when `!rd_n_i && !oe_n_i && !rxf_n_o`.
- **Bus drive.** `data_io` carries the RX head when `!oe_n_i && !rxf_n_o`; otherwise it is Z. This block never drives the bus at any other time.
- **TX FIFO (FPGA to host).**
  - Bus push occurs when `!wr_n_i && !txe_n_o`; it captures `data_io`.
  - Host pop occurs when `host_rvalid_o && host_rready_i`.
  - `host_rvalid_o` is combinational (count != 0). `host_rdata_o` is the memory head.
- **Ignored strobes.**
  - A push into a full FIFO is ignored.
  - A pop from an empty FIFO is ignored.
  - `rd_n_i` low while `oe_n_i` is high pops nothing.
- **Same-cycle events.** A push and a pop on the same FIFO in the same cycle are both performed; the count is unchanged. This holds at full and at empty only when the flag permits each operation.
- **Flags.** `rxf_n_o` and `txe_n_o` are registered:
  - `rxf_n_o` <= (next RX count == 0);
  - `txe_n_o` <= (next TX count == DEPTH).
  - The flag therefore deasserts on the same edge that consumes the last entry or fills the last slot, so no overrun or underrun is possible.
- **No FSM beyond the FIFOs.** The bus protocol is enforced by the flags. The checker described under Configuration is the only extra state.

## Timing
- **Reset values.**
  - `rxf_n_o`=1, `txe_n_o`=1, `err_o`=0, `data_io`=Z.
  - All pointers and counts = 0.
  - `host_wready_o`=1 and `host_rvalid_o`=0 (both follow from the counts).
- **First edge after `rst_n_i` rises.** `txe_n_o` goes to 0, because the TX FIFO is empty.
- **Host write to bus.** A host write on edge N sets `rxf_n_o` low after edge N. The first byte is visible on `data_io` in the cycle after `oe_n_i` is sampled low.
- **Read latency.** With `oe_n_i` and `rd_n_i` both low, one byte pops per edge. `data_io` shows the new head immediately after each edge.
- **Bus write.** A bus write on edge N is visible on `host_rdata_o`/`host_rvalid_o` after edge N.
- **Reset mid-transfer.** Asserting reset during a transfer clears both FIFOs immediately and floats `data_io` asynchronously.

## Configuration
- Macro: `USB_FIFO_EMU_CHECK_EN`.
- **Defined:** `err_o` is set, and held until reset, on any of the following:
  - `!oe_n_i && !wr_n_i` (bus contention);
  - `!rd_n_i` while `oe_n_i` was high on the previous edge (the OE-before-RD rule);
  - `!rd_n_i` while `rxf_n_o` is high;
  - `!wr_n_i` while `txe_n_o` is high.
- **Undefined:** `err_o` is tied to 0 and no checker logic is built. FIFO behaviour is identical in both builds.

## Test plan
- **Reset release:** release reset -> `rxf_n_o`=1, `txe_n_o` 1->0 one edge later, `data_io`=Z, `err_o`=0.
- **Host to FPGA:** host writes 0x11, 0x22, 0x33; then `oe_n_i` goes low, and `rd_n_i` goes low one cycle later for 3 cycles -> `data_io` shows 0x11, 0x22, 0x33 in order; `rxf_n_o` rises on the third pop edge; `err_o` stays 0.
- **Full TX FIFO:** `wr_n_i` held low for 20 cycles with `host_rready_i`=0 -> exactly 16 bytes are captured and `txe_n_o` rises on the 16th edge. Then `host_rready_i`=1 -> the host sees those 16 bytes in order and `txe_n_o` returns low.
- **Simultaneous push and pop:** the TX FIFO holds 15 entries; bus push and host pop happen on the same edge -> count stays 15, `txe_n_o` stays 0. Sustain this across 40 cycles -> no data loss through pointer wrap.
- **Checker (`USB_FIFO_EMU_CHECK_EN` defined):** drive `oe_n_i`=0 and `wr_n_i`=0 together -> `err_o`=1 and it stays 1 until reset. Separately, drive `rd_n_i`=0 in the same cycle `oe_n_i` first falls -> `err_o`=1.
- **Reset mid-read:** assert `rst_n_i` while bytes are being popped -> `data_io`=Z immediately; after release both FIFOs are empty.
